cpu_sram_arbiter: RTL and testbench
===================================

Name: cpu_sram_arbiter

Overview:
Shares one synchronous single-port SRAM (1-cycle read latency) between the CPU instruction-fetch and data-access channels.
- Both channels use a req/addr_ok/data_ok sram-like handshake.
- Sits between the pipeline memory interfaces and the unified SRAM.
- Arbitrates per cycle, issues at most one access per cycle, and routes each response back to its owner.
- Fully pipelined: a new request may be accepted in the same cycle an earlier response returns.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between inst and data; 1 = fixed priority, data wins.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction-channel request
- inst_wr  in  1  1 = write
- inst_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr  in  AW  byte address
- inst_wdata  in  32  write data, already lane-replicated
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  response valid this cycle
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/AW/32  data channel, same meaning as inst_*
- data_addr_ok, data_data_ok  out  1  data channel, same meaning as inst_*
- data_rdata  out  32  data channel read data
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  byte write strobes
- sram_addr  out  AW  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Grant (combinational):
  - Only one req high: that channel wins.
  - Both high, PRIO_MODE=1: data wins.
  - Both high, PRIO_MODE=0: the channel not granted last wins. last_grant register resets to "inst", so the first collision goes to data.
  - last_grant updates only on cycles with a grant.
- Acceptance at cycle T:
  - Granted channel's addr_ok=1 in T. The loser's addr_ok=0; it must hold its req and inputs.
  - sram_en=1 in T; sram_addr/sram_wdata = winner's addr/wdata.
- Write strobes, keyed on {size, addr[1:0]}:
  - Reads: sram_wen=0.
  - Byte: 0001<<addr[1:0].
  - Half at addr[1:0]=0: 0011. Half at addr[1:0]=2: 1100.
  - Word at addr[1:0]=0: 1111.
  - Any other combination (misaligned, or size=3): sram_wen=0, but the access still completes with data_ok.
- Response at T+1:
  - Registered rsp_valid/rsp_owner (set at T) drive the owner's data_ok=1 in T+1, for both reads and writes.
  - Both rdata outputs = sram_rdata (broadcast). Only the owner's data_ok qualifies it.
  - Exactly one data_ok per accepted request, in grant order. Never a data_ok without a prior addr_ok.
- Back-to-back: acceptance in T+1 is legal while the T response is returning. Sustained throughput is 1 access/cycle.
- No request in a cycle: sram_en=0, sram_wen=0. rsp_valid clears at the next edge.
- Reset (resetn=0, at any time, including mid-operation):
  - Immediately forces rsp_valid=0 and last_grant=inst.
  - addr_ok, data_ok, sram_en, sram_wen are all 0 while resetn=0.
  - An in-flight response is dropped; no data_ok after reset release.
  - Operation resumes on the first edge with resetn=1.
- State: rsp_valid, rsp_owner, last_grant. The implicit FSM is IDLE (rsp_valid=0) / RESP (rsp_valid=1); each cycle's next state is RESP iff a grant occurs.

Decomposition:
- Shared package/header:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
  - owner encoding OWN_INST=0, OWN_DATA=1
  - PRIO_RR=0, PRIO_DATA=1
- Sub-module: one natural sub-module, sram_wen_gen (combinational size+addr -> 4-bit strobe), reusable by later data-path stages.
- Top level holds the arbiter and response-tracking registers.

Test Plan:
- Reset: resetn=0 with inst_req=1 pending → all addr_ok/data_ok/sram_en=0. After release, first inst read at 0xBFC00000 → inst_addr_ok at T; inst_data_ok at T+1 with inst_rdata=SRAM word.
- Collision: PRIO_MODE=0, inst and data reads requested every cycle for 4 cycles → grants alternate D,I,D,I. data_ok/inst_data_ok alternate one cycle later; no loss.
- Fixed priority: PRIO_MODE=1, both req held 3 cycles → data granted 3 times, inst_addr_ok stays 0. Inst granted on the first cycle data_req=0.
- Strobes: data write size=0 addr=0x...03 → wen=1000. size=1 addr=0x...02 → 1100. size=2 addr=0x...00 → 1111. size=2 addr=0x...02 → 0000, but data_ok still asserted.
- Write-then-read: data write 0xDEADBEEF to 0x100 at T, data read 0x100 at T+1 → data_data_ok at T+1 (write) and T+2 (read), rdata=0xDEADBEEF at T+2.
- Reset mid-flight: grant a read at T, drop resetn during T+1 before the edge → no data_ok observed; state clean after release.

Source files
------------

// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings for the CPU instruction/data SRAM arbiter.
package cpu_sram_arbiter_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned STRB_W = DW / 8;
  localparam int unsigned SZ_W   = 2;

  // Access size encodings seen on both CPU channels.
  localparam logic [SZ_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SZ_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SZ_W-1:0] SZ_WORD = 2'd2;

  // Response owner / last-grant encoding.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Arbitration policy selector.
  localparam int unsigned PRIO_RR   = 0;
  localparam int unsigned PRIO_DATA = 1;

  // Response tracker: IDLE = nothing returning, RESP = a response returns this cycle.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rsp_state_e;

  // One-hot grant pair produced by the arbiter each cycle.
  typedef struct packed {
    logic inst;
    logic data;
  } grant_t;

endpackage

// File: rtl/cpu_sram_arbiter_wen_gen.sv
// Byte write strobe generator: size + low address bits -> 4-bit SRAM write enable.
// Unsupported size/alignment combinations produce no strobes.
module sram_wen_gen
  import cpu_sram_arbiter_pkg::*;
(
  input  logic              wr_i,
  input  logic [SZ_W-1:0]   size_i,
  input  logic [1:0]        off_i,
  output logic [STRB_W-1:0] wen_c_o
);

  // Decode the strobe pattern for a naturally aligned write.
  always_comb begin
    wen_c_o = '0;
    if (wr_i) begin
      unique case (size_i)
        SZ_BYTE: wen_c_o = STRB_W'(4'b0001 << off_i);
        SZ_HALF: begin
          if (off_i == 2'd0) begin
            wen_c_o = 4'b0011;
          end else if (off_i == 2'd2) begin
            wen_c_o = 4'b1100;
          end
        end
        SZ_WORD: begin
          if (off_i == 2'd0) begin
            wen_c_o = 4'b1111;
          end
        end
        default: wen_c_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one 1-cycle-latency single-port SRAM between the CPU inst and data channels.
// One access is issued per cycle; its response returns to the owner the next cycle.
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_RR,
  parameter int unsigned AW        = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SZ_W-1:0]   inst_size,
  input  logic [AW-1:0]     inst_addr,
  input  logic [DW-1:0]     inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DW-1:0]     inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SZ_W-1:0]   data_size,
  input  logic [AW-1:0]     data_addr,
  input  logic [DW-1:0]     data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DW-1:0]     data_rdata,

  output logic              sram_en,
  output logic [STRB_W-1:0] sram_wen,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_wdata,
  input  logic [DW-1:0]     sram_rdata
);

  rsp_state_e state_q, state_d;
  logic       rsp_owner_q, rsp_owner_d;
  logic       last_grant_q, last_grant_d;

  grant_t          gnt;
  logic            gnt_any;
  logic            win_wr;
  logic [SZ_W-1:0] win_size;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [STRB_W-1:0] win_wen;

  // Per-cycle arbitration; nothing is granted while reset is held.
  always_comb begin
    gnt = '0;
    if (resetn) begin
      if (inst_req && data_req) begin
        if (PRIO_MODE != PRIO_RR) begin
          gnt.data = 1'b1;
        end else if (last_grant_q == OWN_INST) begin
          gnt.data = 1'b1;
        end else begin
          gnt.inst = 1'b1;
        end
      end else begin
        gnt.inst = inst_req;
        gnt.data = data_req;
      end
    end
  end

  assign gnt_any = gnt.inst | gnt.data;

  // Winner's request fields steer the SRAM port.
  always_comb begin
    win_wr    = 1'b0;
    win_size  = '0;
    win_addr  = '0;
    win_wdata = '0;
    if (gnt.data) begin
      win_wr    = data_wr;
      win_size  = data_size;
      win_addr  = data_addr;
      win_wdata = data_wdata;
    end else if (gnt.inst) begin
      win_wr    = inst_wr;
      win_size  = inst_size;
      win_addr  = inst_addr;
      win_wdata = inst_wdata;
    end
  end

  sram_wen_gen u_wen_gen (
    .wr_i    (win_wr & gnt_any),
    .size_i  (win_size),
    .off_i   (win_addr[1:0]),
    .wen_c_o (win_wen)
  );

  // Response tracker next state, owner bookkeeping and handshake outputs.
  always_comb begin
    state_d      = ST_IDLE;
    rsp_owner_d  = rsp_owner_q;
    last_grant_d = last_grant_q;

    inst_addr_ok = gnt.inst;
    data_addr_ok = gnt.data;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;

    sram_en      = gnt_any;
    sram_wen     = win_wen;
    sram_addr    = win_addr;
    sram_wdata   = win_wdata;

    if (gnt_any) begin
      state_d      = ST_RESP;
      rsp_owner_d  = gnt.data ? OWN_DATA : OWN_INST;
      last_grant_d = gnt.data ? OWN_DATA : OWN_INST;
    end

    unique case (state_q)
      ST_RESP: begin
        inst_data_ok = (rsp_owner_q == OWN_INST);
        data_data_ok = (rsp_owner_q == OWN_DATA);
      end
      default: begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; only the owner's data_ok qualifies it.
  assign inst_rdata = sram_rdata;
  assign data_rdata = sram_rdata;

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      rsp_owner_q  <= OWN_INST;
      last_grant_q <= OWN_INST;
    end else begin
      state_q      <= state_d;
      rsp_owner_q  <= rsp_owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Self-checking bench for cpu_sram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_cpu_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;

  logic        inst_addr_ok_rr, inst_data_ok_rr, data_addr_ok_rr, data_data_ok_rr, sram_en_rr;
  logic [31:0] inst_rdata_rr, data_rdata_rr, sram_addr_rr, sram_wdata_rr, sram_rdata_rr;
  logic [3:0]  sram_wen_rr;
  logic        inst_addr_ok_fp, inst_data_ok_fp, data_addr_ok_fp, data_data_ok_fp, sram_en_fp;
  logic [31:0] inst_rdata_fp, data_rdata_fp, sram_addr_fp, sram_wdata_fp, sram_rdata_fp;
  logic [3:0]  sram_wen_fp;

  logic [31:0] mem_rr [256];
  logic [31:0] mem_fp [256];
  logic [31:0] ref_mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_sram_arbiter #(.PRIO_MODE(0), .AW(32)) dut_rr (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok_rr), .inst_data_ok(inst_data_ok_rr),
    .inst_rdata(inst_rdata_rr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok_rr), .data_data_ok(data_data_ok_rr),
    .data_rdata(data_rdata_rr),
    .sram_en(sram_en_rr), .sram_wen(sram_wen_rr), .sram_addr(sram_addr_rr),
    .sram_wdata(sram_wdata_rr), .sram_rdata(sram_rdata_rr)
  );

  cpu_sram_arbiter #(.PRIO_MODE(1), .AW(32)) dut_fp (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok_fp), .inst_data_ok(inst_data_ok_fp),
    .inst_rdata(inst_rdata_fp),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok_fp), .data_data_ok(data_data_ok_fp),
    .data_rdata(data_rdata_fp),
    .sram_en(sram_en_fp), .sram_wen(sram_wen_fp), .sram_addr(sram_addr_fp),
    .sram_wdata(sram_wdata_fp), .sram_rdata(sram_rdata_fp)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h00010001;
  endfunction

  // Expected byte strobes from the size/alignment rules.
  function automatic logic [3:0] exp_strobe(input logic [1:0] sz, input logic [31:0] a);
    int nbytes;
    int off;
    if (sz == 2'd3) return 4'b0000;
    nbytes = 1 << sz;
    off    = int'(a[1:0]);
    if ((off % nbytes) != 0) return 4'b0000;
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  // Synchronous SRAM models (1-cycle read latency), reloaded while in reset.
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem_rr[i] <= init_word(i);
    end else if (sram_en_rr) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen_rr[b]) mem_rr[sram_addr_rr[9:2]][8*b +: 8] <= sram_wdata_rr[8*b +: 8];
      sram_rdata_rr <= mem_rr[sram_addr_rr[9:2]];
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem_fp[i] <= init_word(i);
    end else if (sram_en_fp) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen_fp[b]) mem_fp[sram_addr_fp[9:2]][8*b +: 8] <= sram_wdata_fp[8*b +: 8];
      sram_rdata_fp <= mem_fp[sram_addr_fp[9:2]];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic set_inst(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    inst_req = 1'b1; inst_wr = wr; inst_size = sz; inst_addr = a; inst_wdata = wd;
  endtask

  task automatic set_data(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    idle_all();
    set_inst(1'b0, 2'd2, 32'hBFC00000, 32'h0);
    data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++;
    if ({inst_addr_ok_rr, inst_data_ok_rr, data_addr_ok_rr, data_data_ok_rr, sram_en_rr, sram_wen_rr} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_rr: got ok/en/wen=%b want 0", {inst_addr_ok_rr, inst_data_ok_rr, data_addr_ok_rr, data_data_ok_rr, sram_en_rr, sram_wen_rr});
    end
    n_cmp++;
    if ({inst_addr_ok_fp, inst_data_ok_fp, data_addr_ok_fp, data_data_ok_fp, sram_en_fp, sram_wen_fp} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_fp: got ok/en/wen=%b want 0", {inst_addr_ok_fp, inst_data_ok_fp, data_addr_ok_fp, data_data_ok_fp, sram_en_fp, sram_wen_fp});
    end
  endtask

  task automatic test_first_fetch;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({inst_addr_ok_rr, data_addr_ok_rr, sram_en_rr} !== 3'b101) begin
      n_bad++;
      $display("FAIL fetch_accept: got iok/dok/en=%b want 101", {inst_addr_ok_rr, data_addr_ok_rr, sram_en_rr});
    end
    n_cmp++;
    if (sram_addr_rr !== 32'hBFC00000 || sram_wen_rr !== 4'b0) begin
      n_bad++;
      $display("FAIL fetch_sram: got addr=%h wen=%b want bfc00000/0000", sram_addr_rr, sram_wen_rr);
    end
    tick();
    idle_all();
    @(negedge clk);
    n_cmp++;
    if ({inst_data_ok_rr, data_data_ok_rr} !== 2'b10 || inst_rdata_rr !== init_word(0)) begin
      n_bad++;
      $display("FAIL fetch_resp: got iok/dok=%b rdata=%h want 10/%h", {inst_data_ok_rr, data_data_ok_rr}, inst_rdata_rr, init_word(0));
    end
    n_cmp++;
    if (inst_data_ok_fp !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_resp_fp: got %b want 1", inst_data_ok_fp);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({inst_data_ok_rr, data_data_ok_rr} !== 2'b00) begin
      n_bad++;
      $display("FAIL fetch_single_rsp: got %b want 00", {inst_data_ok_rr, data_data_ok_rr});
    end
  endtask

  // Round-robin: grants alternate D,I,D,I starting with data.
  task automatic test_collision;
    logic exp_d, prev_d;
    tick();
    set_inst(1'b0, 2'd2, 32'h10, 32'h0);
    set_data(1'b0, 2'd2, 32'h20, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_d = (k % 2 == 0);
      n_cmp++;
      if (k < 4 && {data_addr_ok_rr, inst_addr_ok_rr} !== {exp_d, !exp_d}) begin
        n_bad++;
        $display("FAIL collision_grant[%0d]: got d/i=%b want %b", k, {data_addr_ok_rr, inst_addr_ok_rr}, {exp_d, !exp_d});
      end else if (k == 4 && {data_addr_ok_rr, inst_addr_ok_rr} !== 2'b00) begin
        n_bad++;
        $display("FAIL collision_idle: got d/i=%b want 00", {data_addr_ok_rr, inst_addr_ok_rr});
      end
      if (k > 0) begin
        prev_d = ((k - 1) % 2 == 0);
        n_cmp++;
        if ({data_data_ok_rr, inst_data_ok_rr} !== {prev_d, !prev_d} ||
            (prev_d ? data_rdata_rr : inst_rdata_rr) !== (prev_d ? init_word(8) : init_word(4))) begin
          n_bad++;
          $display("FAIL collision_rsp[%0d]: got d/i=%b rd=%h/%h want %b", k, {data_data_ok_rr, inst_data_ok_rr},
                   data_rdata_rr, inst_rdata_rr, {prev_d, !prev_d});
        end
      end
      tick();
      if (k == 3) idle_all();
    end
  endtask

  // Fixed priority: data wins while requesting; inst gets in once data drops.
  task automatic test_fixed_priority;
    logic exp_d;
    set_inst(1'b0, 2'd2, 32'h14, 32'h0);
    set_data(1'b0, 2'd2, 32'h28, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) data_req = 1'b0;
      @(negedge clk);
      exp_d = (k < 3);
      n_cmp++;
      if ({data_addr_ok_fp, inst_addr_ok_fp} !== {exp_d, !exp_d}) begin
        n_bad++;
        $display("FAIL fixed_prio[%0d]: got d/i=%b want %b", k, {data_addr_ok_fp, inst_addr_ok_fp}, {exp_d, !exp_d});
      end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_strobes;
    logic [1:0]  sz  [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
    logic [31:0] ad  [7] = '{32'h43, 32'h42, 32'h40, 32'h42, 32'h40, 32'h41, 32'h40};
    logic [3:0]  wen [7] = '{4'b1000, 4'b1100, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    for (int k = 0; k < 8; k++) begin
      if (k < 7) set_data(1'b1, sz[k], ad[k], 32'h11223344);
      else idle_all();
      @(negedge clk);
      if (k < 7) begin
        n_cmp++;
        if (data_addr_ok_rr !== 1'b1 || sram_wen_rr !== wen[k]) begin
          n_bad++;
          $display("FAIL strobe[%0d]: got aok=%b wen=%b want 1/%b", k, data_addr_ok_rr, sram_wen_rr, wen[k]);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (data_data_ok_rr !== 1'b1) begin
          n_bad++;
          $display("FAIL strobe_rsp[%0d]: got data_ok=%b want 1", k, data_data_ok_rr);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_then_read;
    set_data(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    n_cmp++;
    if (sram_wen_rr !== 4'b1111 || sram_wdata_rr !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL wr_issue: got wen=%b wdata=%h want 1111/deadbeef", sram_wen_rr, sram_wdata_rr);
    end
    tick();
    set_data(1'b0, 2'd2, 32'h100, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (data_data_ok_rr !== 1'b1 || data_addr_ok_rr !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_rsp_rd_acc: got dok=%b aok=%b want 1/1", data_data_ok_rr, data_addr_ok_rr);
    end
    tick();
    idle_all();
    @(negedge clk);
    n_cmp++;
    if (data_data_ok_rr !== 1'b1 || data_rdata_rr !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rd_after_wr: got dok=%b rdata=%h want 1/deadbeef", data_data_ok_rr, data_rdata_rr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (data_data_ok_rr !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_after_wr_quiet: got dok=%b want 0", data_data_ok_rr);
    end
  endtask

  task automatic test_reset_midflight;
    tick();
    set_data(1'b0, 2'd2, 32'h24, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (data_addr_ok_rr !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_accept: got %b want 1", data_addr_ok_rr);
    end
    tick();
    idle_all();
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({inst_data_ok_rr, data_data_ok_rr, sram_en_rr} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_drop: got iok/dok/en=%b want 000", {inst_data_ok_rr, data_data_ok_rr, sram_en_rr});
    end
    tick();
    tick();
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({inst_data_ok_rr, data_data_ok_rr} !== 2'b00) begin
      n_bad++;
      $display("FAIL midrst_no_rsp: got %b want 00", {inst_data_ok_rr, data_data_ok_rr});
    end
    tick();
    set_inst(1'b0, 2'd2, 32'h30, 32'h0);
    set_data(1'b0, 2'd2, 32'h34, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({data_addr_ok_rr, inst_addr_ok_rr} !== 2'b10) begin
      n_bad++;
      $display("FAIL midrst_last_grant: got d/i=%b want 10", {data_addr_ok_rr, inst_addr_ok_rr});
    end
    tick();
    idle_all();
    tick();
  endtask

  // Random traffic on the round-robin instance against a transaction model.
  task automatic test_random;
    logic        ip, iw, dp, dw, gi, gd, last_d;
    logic [1:0]  isz, dsz;
    logic [31:0] ia, iwd, da, dwd;
    logic        exp_v, exp_own, exp_rd;
    logic [31:0] exp_rdata, wa, wd;
    logic [1:0]  wsz;
    logic        ww;
    logic [3:0]  m;
    resetn = 1'b0;
    idle_all();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    ip = 1'b0; dp = 1'b0; last_d = 1'b0; exp_v = 1'b0; exp_own = 1'b0; exp_rd = 1'b0; exp_rdata = '0;
    iw = 1'b0; dw = 1'b0; isz = '0; dsz = '0; ia = '0; da = '0; iwd = '0; dwd = '0;
    for (int c = 0; c < 600; c++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1'b1; iw = ($urandom_range(0, 3) == 0); isz = 2'($urandom_range(0, 3));
        ia = 32'h200 + 32'($urandom_range(0, 511)); iwd = $urandom;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1'b1; dw = ($urandom_range(0, 2) == 0); dsz = 2'($urandom_range(0, 3));
        da = 32'h200 + 32'($urandom_range(0, 511)); dwd = $urandom;
      end
      inst_req = ip; inst_wr = iw; inst_size = isz; inst_addr = ia; inst_wdata = iwd;
      data_req = dp; data_wr = dw; data_size = dsz; data_addr = da; data_wdata = dwd;
      @(negedge clk);
      gi = ip && (!dp || last_d);
      gd = dp && (!ip || !last_d);
      n_cmp++;
      if ({inst_addr_ok_rr, data_addr_ok_rr, sram_en_rr} !== {gi, gd, gi | gd}) begin
        n_bad++;
        $display("FAIL rnd_grant[%0d]: got i/d/en=%b want %b", c, {inst_addr_ok_rr, data_addr_ok_rr, sram_en_rr}, {gi, gd, gi | gd});
      end
      ww = gd ? dw : iw; wsz = gd ? dsz : isz; wa = gd ? da : ia; wd = gd ? dwd : iwd;
      m = ((gi | gd) && ww) ? exp_strobe(wsz, wa) : 4'b0000;
      n_cmp++;
      if (sram_wen_rr !== m || ((gi | gd) && (sram_addr_rr !== wa || sram_wdata_rr !== wd))) begin
        n_bad++;
        $display("FAIL rnd_sram[%0d]: got wen=%b a=%h wd=%h want %b/%h/%h", c, sram_wen_rr, sram_addr_rr, sram_wdata_rr, m, wa, wd);
      end
      n_cmp++;
      if ({inst_data_ok_rr, data_data_ok_rr} !== {exp_v && !exp_own, exp_v && exp_own} ||
          (exp_v && exp_rd && (exp_own ? data_rdata_rr : inst_rdata_rr) !== exp_rdata)) begin
        n_bad++;
        $display("FAIL rnd_rsp[%0d]: got i/d=%b rd=%h want %b/%h", c, {inst_data_ok_rr, data_data_ok_rr},
                 exp_own ? data_rdata_rr : inst_rdata_rr, {exp_v && !exp_own, exp_v && exp_own}, exp_rdata);
      end
      exp_v = gi | gd;
      if (gi | gd) begin
        exp_own   = gd;
        exp_rd    = !ww;
        exp_rdata = ref_mem[wa[9:2]];
        for (int b = 0; b < 4; b++) if (m[b]) ref_mem[wa[9:2]][8*b +: 8] = wd[8*b +: 8];
        last_d = gd;
      end
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
      tick();
    end
    idle_all();
    @(negedge clk);
    n_cmp++;
    if ({inst_data_ok_rr, data_data_ok_rr} !== {exp_v && !exp_own, exp_v && exp_own}) begin
      n_bad++;
      $display("FAIL rnd_drain: got %b want %b", {inst_data_ok_rr, data_data_ok_rr}, {exp_v && !exp_own, exp_v && exp_own});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_collision();
    test_fixed_priority();
    test_strobes();
    test_write_then_read();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
